// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with DATA_W data bits, optional even/odd parity and 1 or 2 stop bits.
// Latency: a word written into an empty, enabled, idle block drives its start bit one cycle after the write edge.
// Backpressure: none toward the host; a write into a full FIFO with no pop that cycle is dropped and Tx_OVF sticks.

// uart_tx_fifo_buf: generic word FIFO with registered full/empty flags.
// Latency: a pushed word is visible at pop_dat on the cycle after the push edge.
// Backpressure: push_rdy low when full unless a pop happens in the same cycle.
module uart_tx_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a word then.
  assign do_pop   = pop_rdy && !empty;
  assign push_rdy = !full || do_pop;
  assign do_push  = push_vld && push_rdy;
  assign pop_dat  = mem[rd_ptr];

  // Occupancy after this edge; the flags are registered from it.
  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + (AW+1)'(1);
      2'b01:   cnt_nxt = cnt - (AW+1)'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Storage array; contents need no reset because occupancy governs validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_FREQ   = 100000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Tx_DATA,
  input  logic              Tx_WR,
  input  logic              Tx_EN,
  input  logic [2:0]        baud_select,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic              TxD,
  output logic              Tx_BUSY,
  output logic              Tx_FULL,
  output logic              Tx_EMPTY,
  output logic              Tx_OVF
);

  // Cycles per 1/16-bit sample tick, rounded to nearest.
  function automatic int calc_div(input int rate);
    return (CLK_FREQ + 8 * rate) / (16 * rate);
  endfunction

  localparam int DIV_300    = calc_div(300);
  localparam int DIV_1200   = calc_div(1200);
  localparam int DIV_4800   = calc_div(4800);
  localparam int DIV_9600   = calc_div(9600);
  localparam int DIV_19200  = calc_div(19200);
  localparam int DIV_38400  = calc_div(38400);
  localparam int DIV_57600  = calc_div(57600);
  localparam int DIV_115200 = calc_div(115200);
  localparam int DIV_W      = $clog2(DIV_300 + 1);
  localparam int BIT_W      = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] fifo_dat;
  logic              fifo_push_rdy;
  logic              start_frame;
  logic              bit_done;
  logic [DIV_W-1:0]  div_sel;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [3:0]        tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_q;
  logic              par_en_q;
  logic              two_stop_q;

  // The FIFO is popped only on the edge that launches a frame.
  uart_tx_fifo_buf #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_vld (Tx_WR),
    .push_dat (Tx_DATA),
    .push_rdy (fifo_push_rdy),
    .pop_rdy  (start_frame),
    .pop_dat  (fifo_dat),
    .full     (Tx_FULL),
    .empty    (Tx_EMPTY)
  );

  assign start_frame = (state_q == IDLE) && Tx_EN && !Tx_EMPTY;
  assign bit_done    = (div_cnt == div_q - DIV_W'(1)) && (tick_cnt == 4'd15);
  assign Tx_BUSY     = !Tx_EMPTY || (state_q != IDLE);

  // Baud divider lookup; sampled only at frame start.
  always_comb begin
    div_sel = DIV_W'(DIV_115200);
    case (baud_select)
      3'd0:    div_sel = DIV_W'(DIV_300);
      3'd1:    div_sel = DIV_W'(DIV_1200);
      3'd2:    div_sel = DIV_W'(DIV_4800);
      3'd3:    div_sel = DIV_W'(DIV_9600);
      3'd4:    div_sel = DIV_W'(DIV_19200);
      3'd5:    div_sel = DIV_W'(DIV_38400);
      3'd6:    div_sel = DIV_W'(DIV_57600);
      default: div_sel = DIV_W'(DIV_115200);
    endcase
  end

  // Frame sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and line level; dropping Tx_EN abandons the frame in progress.
  always_comb begin
    state_d = state_q;
    TxD     = 1'b1;
    case (state_q)
      IDLE: begin
        if (start_frame) state_d = START;
      end
      START: begin
        TxD = 1'b0;
        if (!Tx_EN)        state_d = IDLE;
        else if (bit_done) state_d = DATA;
      end
      DATA: begin
        TxD = shreg[0];
        if (!Tx_EN) begin
          state_d = IDLE;
        end else if (bit_done && (bit_cnt == BIT_W'(DATA_W - 1))) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        TxD = par_q;
        if (!Tx_EN)        state_d = IDLE;
        else if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (!Tx_EN)                                     state_d = IDLE;
        else if (bit_done && (stop_cnt == two_stop_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-frame datapath: config latch at launch, divider, bit and stop counters, shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= '0;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else if (start_frame) begin
      shreg      <= fifo_dat;
      par_q      <= (^fifo_dat) ^ (parity_mode == 2'b10);
      par_en_q   <= parity_mode[0] ^ parity_mode[1];
      two_stop_q <= two_stop;
      div_q      <= div_sel;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else if (state_q != IDLE) begin
      if (div_cnt == div_q - DIV_W'(1)) begin
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 4'd1;
      end else begin
        div_cnt  <= div_cnt + DIV_W'(1);
      end
      if (bit_done && (state_q == DATA)) begin
        shreg   <= {1'b0, shreg[DATA_W-1:1]};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (bit_done && (state_q == STOP)) begin
        stop_cnt <= 1'b1;
      end
    end
  end

  // Sticky overflow: a write the FIFO could not accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Tx_OVF <= 1'b0;
    end else if (Tx_WR && !fifo_push_rdy) begin
      Tx_OVF <= 1'b1;
    end
  end

endmodule
